syn_current_accum: RTL

- Upstream stage of the two-neuron current decay stage.
- Collects weighted synaptic events for neuron 1 and neuron 2 during one simulation timestep.
- At the timestep boundary it delivers the summed currents as curr_in1/curr_in2, with a one-cycle write strobe that loads the decay stage.
- A small event FIFO decouples the bursty spike router from the accumulator.

---
 rtl/syn_current_accum.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/syn_current_accum.sv
// Synaptic current accumulator: event FIFO feeding two saturating accumulators,
// delivered to the decay stage as a one-cycle write at each timestep boundary.
module syn_current_accum #(
   parameter int W     = 17,
   parameter int DEPTH = 4,
   parameter int CW    = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ev_valid,
   output logic         ev_ready,
   input  logic         ev_sel,
   input  logic [W-1:0] ev_weight,
   input  logic         step,
   output logic         busy,
   output logic         write,
   output logic [W-1:0] curr_in1,
   output logic [W-1:0] curr_in2,
   output logic         sat
);

   localparam int AW = CW - 1;

   typedef enum logic [1:0] {ACCUM, DRAIN, FLUSH} state_t;

   state_t          state, state_nxt;
   logic [W:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count, drain_cnt, drain_cnt_nxt, remain;
   logic [W-1:0]    acc1, acc2, acc1_nxt, acc2_nxt;
   logic            sat_pend, sat_pend_nxt;
   logic            push, pop, full, empty;
   logic [W:0]      head;
   logic [W-1:0]    add_a, sum_sat;
   logic [W:0]      wide;
   logic            add_ovf;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign ev_ready = !full;
   assign push     = ev_valid && ev_ready;
   assign head     = mem[rd_ptr];
   assign busy     = (state == DRAIN) || (state == FLUSH);

   // Saturating add of the head weight into whichever accumulator it targets
   always_comb begin
      add_a   = head[W] ? acc2 : acc1;
      wide    = {add_a[W-1], add_a} + {head[W-1], head[W-1:0]};
      add_ovf = wide[W] ^ wide[W-1];
      if (!add_ovf)
         sum_sat = wide[W-1:0];
      else if (wide[W])
         sum_sat = {1'b1, {(W-1){1'b0}}};
      else
         sum_sat = {1'b0, {(W-1){1'b1}}};
   end

   always_comb begin
      state_nxt     = state;
      drain_cnt_nxt = drain_cnt;
      pop           = 1'b0;
      remain        = '0;
      acc1_nxt      = acc1;
      acc2_nxt      = acc2;
      sat_pend_nxt  = sat_pend;
      case (state)
         ACCUM: begin
            pop    = !empty;
            remain = count - CW'(pop);
            if (step) begin
               drain_cnt_nxt = remain;
               state_nxt     = (remain != '0) ? DRAIN : FLUSH;
            end
         end
         DRAIN: begin
            pop = !empty && (drain_cnt != '0);
            if (pop) begin
               drain_cnt_nxt = drain_cnt - CW'(1);
               if (drain_cnt == CW'(1))
                  state_nxt = FLUSH;
            end
         end
         FLUSH: begin
            state_nxt    = ACCUM;
            acc1_nxt     = '0;
            acc2_nxt     = '0;
            sat_pend_nxt = 1'b0;
         end
         default: state_nxt = ACCUM;
      endcase
      if (pop) begin
         if (head[W])
            acc2_nxt = sum_sat;
         else
            acc1_nxt = sum_sat;
         if (add_ovf)
            sat_pend_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= {ev_sel, ev_weight};
   end

   // Outputs load on the edge entering FLUSH so they are valid with write
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ACCUM;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         drain_cnt <= '0;
         acc1      <= '0;
         acc2      <= '0;
         sat_pend  <= 1'b0;
         write     <= 1'b0;
         curr_in1  <= '0;
         curr_in2  <= '0;
         sat       <= 1'b0;
      end else begin
         state     <= state_nxt;
         drain_cnt <= drain_cnt_nxt;
         acc1      <= acc1_nxt;
         acc2      <= acc2_nxt;
         sat_pend  <= sat_pend_nxt;
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         write <= (state_nxt == FLUSH);
         if (state_nxt == FLUSH) begin
            curr_in1 <= acc1_nxt;
            curr_in2 <= acc2_nxt;
            sat      <= sat_pend_nxt;
         end
      end
   end

endmodule
